// File: rtl/spi_rx_multilane_if.sv
// Serial beat input and packet stream output bundle for spi_rx_multilane.
// master = beat source / stream sink, slave = the receiver.
interface spi_rx_multilane_if #(
    parameter int unsigned LANES   = 1,
    parameter int unsigned PKT_LEN = 32
);
    logic [LANES-1:0]   sdata;
    logic               svalid;
    logic               ssync;
    logic [PKT_LEN-1:0] m_data;
    logic               m_valid;
    logic               m_ready;

    modport master (
        output sdata, svalid, ssync, m_ready,
        input  m_data, m_valid
    );
    modport slave (
        input  sdata, svalid, ssync, m_ready,
        output m_data, m_valid
    );
endinterface

// File: rtl/spi_rx_multilane.sv
// Multi-lane serial deserialiser with packet FIFO, resync and overflow accounting.
// Optional even-parity beat per packet enabled by defining RX_PARITY_EN.
module spi_rx_multilane #(
    parameter int unsigned LANES      = 1,
    parameter int unsigned PKT_LEN    = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                        sclk,
    input  logic                        aresetn,
    spi_rx_multilane_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        ovf_clr,
    output logic [15:0]                 drop_count,
    output logic [15:0]                 perr_count
);
    localparam int unsigned BEATS = PKT_LEN / LANES;
    localparam int unsigned CW    = $clog2(BEATS + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;

`ifdef RX_PARITY_EN
    localparam logic [CW-1:0] PAR_BEAT = CW'(BEATS);
`else
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
`endif

    logic [CW-1:0]      cnt_q, cnt_d, base_cnt;
    logic [PKT_LEN-1:0] sh_q, sh_d, base_sh, word;
    logic               push_req;
    logic [PKT_LEN-1:0] push_data;
`ifdef RX_PARITY_EN
    logic               perr_evt;
`endif

    always_comb begin
        // ssync restarts assembly; a beat in the same cycle becomes beat 0
        base_sh  = bus.ssync ? '0 : sh_q;
        base_cnt = bus.ssync ? '0 : cnt_q;
        if (MSB_FIRST != 0) begin
            word = (base_sh << LANES) | PKT_LEN'(bus.sdata);
        end else begin
            word = (base_sh >> LANES) | (PKT_LEN'(bus.sdata) << (PKT_LEN - LANES));
        end
        sh_d      = base_sh;
        cnt_d     = base_cnt;
        push_req  = 1'b0;
        push_data = word;
`ifdef RX_PARITY_EN
        perr_evt  = 1'b0;
        if (bus.svalid) begin
            if (base_cnt == PAR_BEAT) begin
                // parity beat: base_cnt can only reach here with ssync low
                cnt_d     = '0;
                push_data = sh_q;
                if (^{sh_q, bus.sdata[0]}) perr_evt = 1'b1;
                else                       push_req = 1'b1;
            end else begin
                sh_d  = word;
                cnt_d = base_cnt + 1'b1;
            end
        end
`else
        if (bus.svalid) begin
            sh_d = word;
            if (base_cnt == LAST_BEAT) begin
                cnt_d    = '0;
                push_req = !bus.ssync;
            end else begin
                cnt_d = base_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge sclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    logic [PKT_LEN-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]      level_q;
    logic               full, pop, push, drop;

    assign full        = (level_q == LW'(FIFO_DEPTH));
    assign bus.m_valid = (level_q != '0);
    assign bus.m_data  = mem_q[rd_ptr_q];
    assign pop         = bus.m_valid && bus.m_ready;
    // a pop in the same cycle frees the slot for a completing packet
    assign push        = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign fifo_level  = level_q;

    always_ff @(posedge sclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    logic        overflow_q;
    logic [15:0] drop_q;

    // a drop in the same cycle as ovf_clr survives the clear
    always_ff @(posedge sclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            drop_q     <= ovf_clr ? 16'd1 : (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

`ifdef RX_PARITY_EN
    logic [15:0] perr_q;

    always_ff @(posedge sclk or negedge aresetn) begin
        if (!aresetn) begin
            perr_q <= '0;
        end else if (perr_evt) begin
            perr_q <= ovf_clr ? 16'd1 : (perr_q == 16'hFFFF) ? perr_q : perr_q + 16'd1;
        end else if (ovf_clr) begin
            perr_q <= '0;
        end
    end

    assign perr_count = perr_q;
`else
    assign perr_count = '0;
`endif
endmodule

// File: doc/spi_rx_multilane.md
Name: spi_rx_multilane

Overview:
- Next-generation serial receiver for the ASIC readout link, running entirely in the sclk domain.
- Deserialises 1/2/4/8-lane SPI-like data into PKT_LEN-bit packets.
- Buffers packets in an internal FIFO and presents them on a valid/ready stream.
- Downstream async FIFO handles the crossing to aclk. Adds frame resync, overflow accounting and occupancy reporting.

Parameters:
- LANES, 1, serial data lanes per beat; PKT_LEN must be divisible by LANES.
- PKT_LEN, 32, packet width in bits.
- FIFO_DEPTH, 4, packet buffer entries; power of two, >=2.
- MSB_FIRST, 1, 1: first beat lands in the MSBs; 0: first beat lands in the LSBs.

Ports:
- sclk  in  1  serial clock; all logic on its rising edge.
- aresetn  in  1  asynchronous active-low reset.
- sdata  in  LANES  lane data, sampled when svalid=1.
- svalid  in  1  beat valid.
- ssync  in  1  frame resync pulse; discards any partial packet.
- m_data  out  PKT_LEN  head-of-FIFO packet.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  downstream accept.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a packet was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- drop_count  out  16  packets dropped, saturating at 0xFFFF; cleared by ovf_clr.
- perr_count  out  16  parity failures, saturating at 0xFFFF; cleared by ovf_clr. Tied 0 when RX_PARITY_EN is undefined.

Behaviour:
- Reset values: m_data=0, m_valid=0, fifo_level=0, overflow=0, drop_count=0, perr_count=0. Beat counter, shift register and FIFO pointers are also cleared.
- BEATS = PKT_LEN/LANES. Each cycle with svalid=1 shifts in LANES bits and increments the beat counter.
  - MSB_FIRST=1: register shifts left by LANES, sdata enters the LSBs; sdata[LANES-1] is more significant than sdata[0].
  - MSB_FIRST=0: register shifts right by LANES, sdata enters the MSBs; sdata[0] is less significant than sdata[LANES-1].
- Completion: on the beat where the counter equals BEATS-1, the assembled word (shift register plus current sdata) is pushed on that same edge and the counter returns to 0.
  - Latency: m_valid rises on the edge after the final beat when the FIFO was empty.
- ssync=1: counter and shift register cleared and any partial packet discarded.
  - With svalid=1 in the same cycle, that beat counts as beat 0 of a new packet.
  - ssync on a completing beat: ssync wins, no push.
- svalid=0: no shift, counter holds. Gaps between beats are legal.
- Stream handshake: pop when m_valid && m_ready. m_data is a FIFO register read, stable while m_valid=1 and m_ready=0.
- FIFO full with a completing packet and no pop that cycle:
  - packet dropped, overflow set, drop_count increments (saturating);
  - FIFO contents unchanged.
- Full with simultaneous pop and push: both occur, level unchanged, no drop.
- Empty: m_ready ignored, level does not underflow.
- ovf_clr: clears overflow and both counters. If a drop coincides with ovf_clr, the drop wins: overflow=1, drop_count=1.
- fifo_level: +1 on push-only, -1 on pop-only, unchanged otherwise. Range 0..FIFO_DEPTH.
- Reset mid-packet: partial data lost, FIFO emptied immediately (asynchronous).

Optional Feature:
- Macro RX_PARITY_EN.
- Defined:
  - After the BEATS data beats, one extra svalid beat carries even parity over the packet on sdata[0]; the other lanes are ignored.
  - Push happens on the parity beat, if parity is good.
  - On mismatch: packet discarded, perr_count increments (saturating), overflow unaffected.
  - ssync during the parity beat discards the packet.
  - Latency becomes BEATS+1 beats per packet.
- Undefined: no parity beat, perr_count constant 0.

Test Plan:
- LANES=1, PKT_LEN=32, MSB_FIRST=1: shift 0xA5A5_1234 over 32 contiguous beats -> m_valid=1 one edge after beat 31, m_data=0xA5A5_1234, fifo_level=1.
- LANES=4, MSB_FIRST=0: 8 beats of nibbles 4,3,2,1,8,7,6,5, with an svalid gap of 3 cycles after beat 2 -> m_data=0x5678_1234, counter holds during the gap.
- m_ready=0, FIFO_DEPTH=4: send 6 packets -> level=4, overflow=1, drop_count=2, first 4 packets delivered in order. Then ovf_clr -> overflow=0, drop_count=0.
- FIFO full, a packet completes in the same cycle as m_ready=1 -> no drop, level stays 4, new packet appears last.
- After 10 of 32 beats, pulse ssync with svalid=1, then send 31 more beats of 0xDEAD_BEEF -> exactly one packet, 0xDEAD_BEEF, emitted.
- RX_PARITY_EN defined: send 0x0000_0001 with parity bit 0 (wrong) -> no push, perr_count=1. Resend with parity 1 -> pushed.
